rf_write_sequencer: RTL and testbench

- Upstream write-port front end for the 8x4-bit register file. Drives the file's wrAddr, wrVal and wrEn.
- Buffers incoming write requests in a small FIFO behind a valid/ready handshake, and issues at most one register write per cycle.
- After every reset, sweeps all registers to CLR_VAL before any buffered request is issued. The register file itself has no reset, so this sweep is what gives it a defined state.

---
 rtl/rf_write_sequencer_pkg.sv | 19 +
 rtl/rf_write_sequencer_if.sv | 16 +
 rtl/rf_write_sequencer_fifo.sv | 72 +++++++
 rtl/rf_write_sequencer.sv | 108 ++++++++++
 tb/tb_rf_write_sequencer.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/rf_write_sequencer_pkg.sv
// Shared widths, FSM state encoding and request record for the register-file
// write-port front end.
package rf_pkg;

  localparam int RF_ADDR_W   = 3;
  localparam int RF_DATA_W   = 4;
  localparam int RF_NUM_REGS = 8;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } rf_state_e;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } rf_wr_req_t;

endpackage

// File: rtl/rf_write_sequencer_if.sv
// Upstream write-request handshake: the producer drives valid/addr/data and the
// sequencer answers with ready.
interface rf_write_sequencer_if #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4
);

  logic              valid;
  logic              ready;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] data;

  modport master (output valid, output addr, output data, input ready);
  modport slave  (input valid, input addr, input data, output ready);

endinterface

// File: rtl/rf_write_sequencer_fifo.sv
// Request buffer between the upstream handshake and the write port.
// Storage is unreset; only the pointers and occupancy are cleared.
module rf_req_fifo
  import rf_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  rf_wr_req_t       push_req,
  input  logic             pop,
  output rf_wr_req_t       head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  rf_wr_req_t       mem_q [DEPTH];
  rf_wr_req_t       mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full  = (cnt_q == CNT_W'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign head  = mem_q[rd_ptr_q];

  // DEPTH is a power of two, so plain pointer increments wrap on their own.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_req;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (do_pop && !do_push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/rf_write_sequencer.sv
// Write-port sequencer: clears every register after reset, then drains buffered
// requests into the register file at one write per cycle.
module rf_write_sequencer
  import rf_pkg::*;
#(
  parameter int                ADDR_W  = RF_ADDR_W,
  parameter int                DATA_W  = RF_DATA_W,
  parameter int                DEPTH   = 4,
  parameter logic [DATA_W-1:0] CLR_VAL = '0,
  localparam int NUM_REGS = 2 ** ADDR_W,
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  rf_write_sequencer_if.slave    req,
  output logic [ADDR_W-1:0]      wrAddr,
  output logic [DATA_W-1:0]      wrVal,
  output logic                   wrEn,
  output logic                   init_done,
  output logic [CNT_W-1:0]       fifo_cnt
);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_val_q, wr_val_d;
  logic              wr_en_q, wr_en_d;
  logic              init_done_q, init_done_d;

  rf_wr_req_t        push_req;
  rf_wr_req_t        head;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  // Ready depends only on registered occupancy: a full FIFO refuses even when
  // it is being popped in the same cycle.
  assign req.ready = !fifo_full && rst_n;
  assign push      = req.valid && req.ready;
  assign pop       = (state_q == ST_RUN) && !fifo_empty;
  assign push_req  = '{addr: req.addr, data: req.data};

  rf_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_req (push_req),
    .pop      (pop),
    .head     (head),
    .count    (fifo_cnt),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    wr_addr_d   = wr_addr_q;
    wr_val_d    = wr_val_q;
    wr_en_d     = 1'b0;
    init_done_d = init_done_q;
    unique case (state_q)
      ST_CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = clr_cnt_q;
        wr_val_d  = CLR_VAL;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == ADDR_W'(NUM_REGS - 1)) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (pop) begin
          wr_en_d   = 1'b1;
          wr_addr_d = head.addr;
          wr_val_d  = head.data;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_CLEAR;
      clr_cnt_q   <= '0;
      wr_addr_q   <= '0;
      wr_val_q    <= '0;
      wr_en_q     <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_cnt_q   <= clr_cnt_d;
      wr_addr_q   <= wr_addr_d;
      wr_val_q    <= wr_val_d;
      wr_en_q     <= wr_en_d;
      init_done_q <= init_done_d;
    end
  end

  assign wrAddr    = wr_addr_q;
  assign wrVal     = wr_val_q;
  assign wrEn      = wr_en_q;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_rf_write_sequencer.sv
// Bench for rf_write_sequencer: directed scenarios plus random traffic compared
// against a queue-based model of the sweep-then-drain behaviour.
module tb_rf_write_sequencer;
  import rf_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] wr_addr;
  logic [3:0] wr_val;
  logic       wr_en;
  logic       init_done;
  logic [2:0] fifo_cnt;

  int n_checks = 0;
  int n_errors = 0;

  rf_write_sequencer_if #(.ADDR_W(3), .DATA_W(4)) rq ();

  rf_write_sequencer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (rq),
    .wrAddr    (wr_addr),
    .wrVal     (wr_val),
    .wrEn      (wr_en),
    .init_done (init_done),
    .fifo_cnt  (fifo_cnt)
  );

  always #5 clk = ~clk;

  // Stand-in for the register file, written from the DUT's write port.
  logic [3:0] rf_file [8];
  always @(posedge clk) if (wr_en) rf_file[wr_addr] <= wr_val;

  // Reference model state.
  rf_wr_req_t q[$];
  int         sweep_idx = 0;
  logic       exp_wren = 1'b0;
  logic       exp_init = 1'b0;
  logic [2:0] exp_addr = '0;
  logic [3:0] exp_val = '0;
  logic [3:0] exp_file [8];

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input logic rst, input logic vld, input logic [2:0] a,
                      input logic [3:0] d, output logic acc);
    logic       m_ready;
    rf_wr_req_t e;
    @(negedge clk);
    rst_n    = rst;
    rq.valid = vld;
    rq.addr  = a;
    rq.data  = d;
    #1;
    m_ready = (q.size() != DEPTH) && rst;
    chk_val("req_ready", 32'(rq.ready), 32'(m_ready));
    @(posedge clk);
    if (exp_wren) exp_file[exp_addr] = exp_val;
    acc = 1'b0;
    if (!rst) begin
      q.delete();
      sweep_idx = 0;
      exp_wren  = 1'b0;
      exp_addr  = '0;
      exp_val   = '0;
      exp_init  = 1'b0;
    end else begin
      if (sweep_idx < 8) begin
        exp_wren  = 1'b1;
        exp_addr  = 3'(sweep_idx);
        exp_val   = 4'h0;
        sweep_idx = sweep_idx + 1;
        if (sweep_idx == 8) exp_init = 1'b1;
      end else if (q.size() > 0) begin
        e        = q.pop_front();
        exp_wren = 1'b1;
        exp_addr = e.addr;
        exp_val  = e.data;
      end else begin
        exp_wren = 1'b0;
      end
      if (vld && m_ready) begin
        q.push_back('{addr: a, data: d});
        acc = 1'b1;
      end
    end
    #1;
    chk_val("wrEn", 32'(wr_en), 32'(exp_wren));
    chk_val("wrAddr", 32'(wr_addr), 32'(exp_addr));
    chk_val("wrVal", 32'(wr_val), 32'(exp_val));
    chk_val("init_done", 32'(init_done), 32'(exp_init));
    chk_val("fifo_cnt", 32'(fifo_cnt), 32'(q.size()));
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) tick(1'b1, 1'b0, 3'd0, 4'd0, acc);
  endtask

  task automatic do_reset(input int n);
    logic acc;
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 3'd0, 4'd0, acc);
  endtask

  task automatic send(input logic [2:0] a, input logic [3:0] d);
    logic acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) tick(1'b1, 1'b1, a, d, acc);
    if (!acc) chk_val("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic check_file();
    for (int i = 0; i < 8; i++) chk_val("rf_read", 32'(rf_file[i]), 32'(exp_file[i]));
  endtask

  initial begin
    logic       acc;
    logic       hold;
    logic [2:0] ra;
    logic [3:0] rd;
    int         guard;
    rq.valid = 1'b0;
    rq.addr  = '0;
    rq.data  = '0;

    // Clear sweep from reset.
    do_reset(2);
    idle(10);
    check_file();

    // Single write after init.
    send(3'd5, 4'hA);
    idle(4);
    check_file();
    chk_val("rf5_value", 32'(rf_file[5]), 32'hA);

    // Backpressure during the sweep.
    do_reset(2);
    for (int i = 0; i < 5; i++) send(3'(i), 4'(i + 3));
    idle(8);
    check_file();

    // Back-to-back stream.
    for (int i = 0; i < 8; i++) send(3'(i), ~4'(i));
    idle(4);
    check_file();

    // Same-address ordering.
    send(3'd3, 4'h1);
    send(3'd3, 4'h2);
    send(3'd3, 4'h7);
    idle(4);
    chk_val("rf3_last", 32'(rf_file[3]), 32'h7);

    // Reset with three requests still buffered after the sweep.
    do_reset(1);
    for (int i = 0; i < 4; i++) send(3'(i + 4), 4'(9 + i));
    guard = 0;
    while (!(exp_init && q.size() == 3) && guard < 20) begin
      idle(1);
      guard++;
    end
    chk_val("reach_cnt3", 32'(fifo_cnt), 32'd3);
    do_reset(1);
    idle(14);
    check_file();

    // Random traffic with occasional resets; requests held until accepted.
    hold = 1'b0;
    ra   = '0;
    rd   = '0;
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 63) == 0) begin
        do_reset(1 + $urandom_range(0, 1));
        hold = 1'b0;
      end else begin
        if (!hold) begin
          hold = ($urandom_range(0, 99) < 60);
          ra   = 3'($urandom);
          rd   = 4'($urandom);
        end
        tick(1'b1, hold, ra, rd, acc);
        if (acc) hold = 1'b0;
      end
      if (c % 16 == 15) check_file();
    end
    idle(20);
    check_file();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
